mmio_port_interface: RTL

MMIO_PORT_INTERFACE -- requirements
Module: mmio_port_interface

---
 rtl/sw_if_pkg.sv | 16 +
 rtl/meta_fifo.sv | 52 +++++
 rtl/mmio_port_interface.sv | 111 +++++++++++
 3 files changed

// File: rtl/sw_if_pkg.sv
// Shared register map and STATUS field layout for the switch-port MMIO block.
package sw_if_pkg;

  // Word offsets on the software bus
  localparam int unsigned REG_CTRL      = 0;
  localparam int unsigned REG_STATUS    = 1;
  localparam int unsigned REG_PORT_BASE = 2;

  // CTRL value that puts the switch into experiment mode
  localparam int unsigned CTRL_EXPERIMENT = 2;

  // STATUS bit-field offsets: not_empty flags and sticky overflow flags
  localparam int unsigned STATUS_NE_LSB  = 0;
  localparam int unsigned STATUS_OVF_LSB = 8;

endpackage

// File: rtl/meta_fifo.sv
// Synchronous metadata FIFO. Storage is not reset; only pointers and count are.
// A pop on an empty FIFO is ignored, and a push on a full FIFO only lands when
// a pop happens in the same cycle.
module meta_fifo #(
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/mmio_port_interface.sv
// Software MMIO window onto the switch ports: CTRL/STATUS registers, per-port
// egress metadata FIFOs popped by reads, and a one-shot ingress write path.
module mmio_port_interface
  import sw_if_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             chipselect,
  input  logic                             write,
  input  logic                             read,
  input  logic [ADDR_W-1:0]                address,
  input  logic [DATA_W-1:0]                writedata,
  output logic [DATA_W-1:0]                readdata,
  input  logic [NUM_PORTS-1:0]             interface_in_valid,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] interface_in,
  output logic [NUM_PORTS-1:0]             interface_out_en,
  output logic [DATA_W-1:0]                interface_out,
  output logic                             experimenting
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                             bus_wr, bus_rd, ctrl_sel, status_sel;
  logic [NUM_PORTS-1:0]             port_sel;
  logic [NUM_PORTS-1:0]             fifo_pop, fifo_full, fifo_empty, not_empty;
  logic [NUM_PORTS-1:0][DATA_W-1:0] fifo_rdata;
  logic [NUM_PORTS-1:0][CntW-1:0]   fifo_count;
  logic [NUM_PORTS-1:0]             ovf_set, ovf_clr, overflow_d, overflow_q;
  logic [DATA_W-1:0]                status_word, rd_word;
  logic [DATA_W-1:0]                ctrl_q, readdata_q, out_q;
  logic [NUM_PORTS-1:0]             out_en_q;

  assign bus_wr     = chipselect & write;
  assign bus_rd     = chipselect & read;
  assign ctrl_sel   = (address == ADDR_W'(REG_CTRL));
  assign status_sel = (address == ADDR_W'(REG_STATUS));

  assign readdata         = readdata_q;
  assign interface_out    = out_q;
  assign interface_out_en = out_en_q;
  assign experimenting    = (ctrl_q == DATA_W'(CTRL_EXPERIMENT));

  // Port address decode, FIFO pops and overflow set/clear
  always_comb begin
    port_sel = '0;
    ovf_clr  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_sel[i]  = (address == ADDR_W'(REG_PORT_BASE + i));
      not_empty[i] = (fifo_count[i] != '0);
    end
    fifo_pop = bus_rd ? port_sel : '0;
    // A push is dropped only when full and no pop frees a slot this cycle
    ovf_set = interface_in_valid & fifo_full & ~fifo_pop;
    if (bus_wr && status_sel) ovf_clr = writedata[STATUS_OVF_LSB +: NUM_PORTS];
    // New overflow beats a same-cycle clear
    overflow_d = (overflow_q & ~ovf_clr) | ovf_set;
  end

  // Read data mux; empty ports and unmapped addresses read as zero
  always_comb begin
    status_word = '0;
    status_word[STATUS_NE_LSB +: NUM_PORTS]  = not_empty;
    status_word[STATUS_OVF_LSB +: NUM_PORTS] = overflow_q;
    rd_word = '0;
    if (ctrl_sel)   rd_word = ctrl_q;
    if (status_sel) rd_word = status_word;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_sel[i] && !fifo_empty[i]) rd_word = fifo_rdata[i];
    end
  end

  // Register file, read data, overflow flags and ingress pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      readdata_q <= '0;
      out_q      <= '0;
      out_en_q   <= '0;
      overflow_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      out_en_q   <= bus_wr ? port_sel : '0;
      if (bus_wr && ctrl_sel)   ctrl_q <= writedata;
      if (bus_wr && |port_sel)  out_q  <= writedata;
      if (bus_rd)               readdata_q <= rd_word;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_fifo
    meta_fifo #(
      .DataW (DATA_W),
      .Depth (FIFO_DEPTH)
    ) u_meta_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (interface_in_valid[g]),
      .pop     (fifo_pop[g]),
      .wdata   (interface_in[g]),
      .rdata   (fifo_rdata[g]),
      .full    (fifo_full[g]),
      .empty   (fifo_empty[g]),
      .count   (fifo_count[g])
    );
  end

endmodule
